// File: rtl/led_pattern_blinker.sv
// Multi-channel LED driver: shared prescaler and 8-step sequencer, per-channel OFF/ON/BLINK/PATTERN modes.
// Optional PWM brightness stage enabled by defining LED_PATTERN_BLINKER_PWM_EN.
module led_pattern_blinker #(
  parameter int unsigned NCH      = 4,
  parameter logic        LED_OFF  = 1'b1,
  parameter logic [31:0] TICK_TOP = 32'hFFFFFF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [2*NCH-1:0]   mode_i,
  input  logic [8*NCH-1:0]   pattern_i,
  input  logic               restart_i,
`ifdef LED_PATTERN_BLINKER_PWM_EN
  input  logic [4*NCH-1:0]   brightness_i,
`endif
  output logic [NCH-1:0]     led_o,
  output logic [2:0]         step_o
);

  localparam int unsigned PRESC_W = 32;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned PWM_W   = 4;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_PATTERN = 2'd3
  } mode_e;

  logic [PRESC_W-1:0] presc_q;
  logic [STEP_W-1:0]  step_q;
  logic               tick_c;
  logic [NCH-1:0]     lit_c;
  logic [NCH-1:0]     gate_c;
  logic [NCH-1:0]     led_d_c;

  assign tick_c = (presc_q == '0);

  // Shared timebase; restart wins over a coincident tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= TICK_TOP;
      step_q  <= '0;
    end else if (restart_i) begin
      presc_q <= TICK_TOP;
      step_q  <= '0;
    end else if (tick_c) begin
      presc_q <= TICK_TOP;
      step_q  <= step_q + STEP_W'(1);
    end else begin
      presc_q <= presc_q - PRESC_W'(1);
    end
  end

  // Per-channel lit decision from mode, pattern and the current step.
  always_comb begin
    lit_c = '0;
    for (int n = 0; n < int'(NCH); n++) begin
      unique case (mode_e'(mode_i[2*n +: 2]))
        MODE_OFF:     lit_c[n] = 1'b0;
        MODE_ON:      lit_c[n] = 1'b1;
        MODE_BLINK:   lit_c[n] = ~step_q[0];
        MODE_PATTERN: lit_c[n] = pattern_i[8*n + int'(step_q)];
        default:      lit_c[n] = 1'b0;
      endcase
    end
  end

`ifdef LED_PATTERN_BLINKER_PWM_EN
  logic [PWM_W-1:0] pwm_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
    end
  end

  // Full-scale brightness stays on; zero brightness never passes.
  always_comb begin
    gate_c = '0;
    for (int n = 0; n < int'(NCH); n++) begin
      gate_c[n] = (brightness_i[4*n +: 4] == 4'hF) || (pwm_q < brightness_i[4*n +: 4]);
    end
  end
`else
  assign gate_c = '1;
`endif

  always_comb begin
    led_d_c = {NCH{LED_OFF}};
    for (int n = 0; n < int'(NCH); n++) begin
      led_d_c[n] = (lit_c[n] && gate_c[n]) ? ~LED_OFF : LED_OFF;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_o <= {NCH{LED_OFF}};
    end else begin
      led_o <= led_d_c;
    end
  end

  assign step_o = step_q;

endmodule

// File: doc/led_pattern_blinker.md
LED_PATTERN_BLINKER -- requirements
Module: led_pattern_blinker

Interface
REQ-001 SHALL have parameter NCH, default 4, number of LED channels (1..16).
REQ-002 SHALL have parameter LED_OFF, default 1'b1, output level of an unlit LED; lit level is ~LED_OFF.
REQ-003 SHALL have parameter TICK_TOP, default 32'hFFFFFF, prescaler reload value; one pattern step lasts TICK_TOP+1 clk cycles.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 mode_i  input  2*NCH  per-channel mode, channel n at [2n+1:2n]: 0=OFF, 1=ON, 2=BLINK, 3=PATTERN.
REQ-007 pattern_i  input  8*NCH  per-channel 8-step pattern, channel n at [8n+7:8n], bit k = lit in step k.
REQ-008 restart_i  input  1  synchronous pulse; resynchronises prescaler and step counter.
REQ-009 led_o  output  NCH  registered LED drive, one bit per channel.
REQ-010 step_o  output  3  current shared step index.

Function
REQ-011 Prescaler SHALL be a 32-bit down-counter: at 0 it reloads TICK_TOP and asserts internal tick for that cycle; otherwise it decrements.
REQ-012 Step counter SHALL increment by 1 on each tick, wrapping 7->0; step_o SHALL equal it.
REQ-013 All channels SHALL share one prescaler and one step counter, so channels in the same mode are phase-aligned.
REQ-014 Lit condition per channel: OFF never; ON always; BLINK when step[0]==0; PATTERN when pattern_i bit[step]==1.
REQ-015 led_o[n] SHALL register ~LED_OFF when lit, LED_OFF otherwise, one clk after the mode/pattern/step values that produced it.
REQ-016 mode_i and pattern_i changes SHALL take effect on led_o at the next clk edge, with no restart of step or prescaler.
REQ-017 restart_i high SHALL load prescaler with TICK_TOP and step with 0 in that cycle, taking priority over a simultaneous tick.
REQ-018 With TICK_TOP=0 a tick SHALL occur every cycle and step SHALL advance every cycle.
REQ-019 Prescaler and step SHALL run continuously regardless of modes; no channel in OFF halts the timebase.

Reset
REQ-020 resetn low SHALL asynchronously set led_o to all LED_OFF, prescaler to TICK_TOP, step to 0.
REQ-021 Reset asserted mid-step SHALL discard the partial step; after release the first tick SHALL occur TICK_TOP+1 cycles after the first active edge.
REQ-022 Internal PWM counter (if built) SHALL reset to 0.

Configuration
REQ-023 Macro LED_PATTERN_BLINKER_PWM_EN SHALL, when defined, add input brightness_i (4*NCH, channel n at [4n+3:4n]) and a free-running 4-bit PWM counter incrementing every clk, wrapping 15->0.
REQ-024 With the macro defined, a lit channel SHALL drive ~LED_OFF only when brightness==15 or pwm_cnt<brightness, else LED_OFF; brightness 0 SHALL keep the LED unlit.
REQ-025 Without the macro, brightness_i and the PWM counter SHALL not exist and every lit channel SHALL drive ~LED_OFF continuously.

Verification
REQ-026 NCH=2, TICK_TOP=3, reset then release, mode_i=ON/OFF -> led_o[0]=~LED_OFF, led_o[1]=LED_OFF from second clk; step_o increments every 4 cycles, 7->0 wrap seen after 32 cycles.
REQ-027 Channel 0 BLINK, TICK_TOP=3 -> led_o[0] lit for 4 cycles, unlit for 4 cycles, repeating; lit phase aligned to step_o even values.
REQ-028 Channel 1 PATTERN, pattern_i=8'b1000_0001 -> led_o[1] lit only during steps 0 and 7, i.e. 8 consecutive lit cycles across the wrap, then 24 unlit.
REQ-029 restart_i pulsed when step_o=5 and prescaler=0 (simultaneous tick) -> next cycle step_o=0, next tick 4 cycles later; resetn pulsed mid-step -> led_o=LED_OFF immediately, step_o=0.
REQ-030 PWM_EN defined, channel 0 ON, brightness 4 -> led_o[0] lit exactly 4 of every 16 cycles; brightness 15 -> lit every cycle; brightness 0 -> never lit.
